multi_ch_signature_analyzer: RTL
================================

// Module: multi_ch_signature_analyzer
// PURPOSE
//  Multi-lane signature compactor for BIST of the systolic array outputs. NUM_CH
//  independent MISR lanes compress per-channel DUT data, with optional seed load.
//  A run ends on a sample-count limit or i_stop. The lanes are then XOR-folded to
//  one signature, compared against a golden value, and reported with pass/fail.
// PARAMETERS
//  NUM_CH     4     number of MISR lanes (>=1)
//  DATA_WIDTH 54    bits per lane (x-18 y-18 z-18)
//  CNT_WIDTH  16    sample counter / length width
//  POLY       'h63  DATA_WIDTH-bit feedback tap mask
// PORTS
//  i_clk       in   1                    clock, all logic rising-edge
//  i_rst_n     in   1                    reset, synchronous, active-low
//  i_stop      in   1                    end run after this cycle's samples (RUN only)
//  i_len       in   CNT_WIDTH            run length in sample cycles; 0 = until i_stop
//  i_seed_vld  in   1                    load i_seed_data into all lanes (IDLE only)
//  i_seed_data in   DATA_WIDTH           seed value
//  i_dut_vld   in   NUM_CH               per-lane sample valid
//  i_dut_data  in   NUM_CH*DATA_WIDTH    lane k = bits [k*DW +: DW]
//  i_golden    in   DATA_WIDTH           expected folded signature
//  o_busy      out  1                    state != IDLE
//  o_vld       out  1                    1-cycle pulse, final signature valid
//  o_data      out  DATA_WIDTH           folded signature, held until next DONE
//  o_pass      out  1                    o_data == i_golden sampled in DONE, held
//  o_count     out  CNT_WIDTH            sample cycles absorbed this/last run, held
//  o_overrun   out  1                    sticky: sample arrived in DONE (dropped)
//  o_ch_sig    out  NUM_CH*DATA_WIDTH    live lane signatures
// BEHAVIOUR
//  Reset (i_rst_n=0 at an edge, any state): state=IDLE, lanes=0, counter=0.
//   All outputs read 0. Reset mid-run discards the run.
//  Lane step: step(s,d) = {s[DW-2:0],1'b0} ^ (s[DW-1] ? POLY : 0) ^ d.
//   Lane k steps only when i_dut_vld[k]=1; otherwise it holds.
//  Sample cycle = any i_dut_vld bit set. The counter increments once per sample
//   cycle and saturates at all-ones.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: lanes are 0 on entry.
//   - i_seed_vld=1: lanes <= seed. If any dut_vld is also set, those lanes
//     <= step(seed, data) and count=1. o_overrun is cleared. Go to RUN.
//   - Else, any dut_vld: lanes step from 0, count=1, o_overrun cleared, go to RUN.
//   - i_len is latched on the IDLE->RUN transition.
//   - i_stop is ignored in IDLE.
//   - Seed-only entry with no sample: count=0.
//  RUN: samples are absorbed.
//   - Terminate when i_stop=1, or when latched len!=0 and the counter reaches len
//     with this cycle's sample. Then go to DONE.
//   - i_stop together with a sample: the sample is absorbed first.
//   - i_seed_vld is ignored in RUN.
//  DONE: one cycle.
//   - o_vld=1; o_data <= XOR of all lanes; o_pass <= (fold == i_golden).
//   - o_count <= counter.
//   - Any dut_vld here is dropped and sets o_overrun.
//   - Next cycle: IDLE, lanes and counter cleared. o_data, o_pass, o_count hold.
//  Latency: the last sample at edge t is in the fold. o_vld is high in cycle t+1,
//   and o_data/o_pass are registered in that same cycle.
//  A new run may begin in the cycle right after DONE.
// STRUCTURE
//  Package sig_analyzer_pkg: enum st_sa_state {SA_IDLE, SA_RUN, SA_DONE}, and a
//   function misr_step(s,d,poly) shared with the sub-module.
//  Sub-module misr_lane #(DATA_WIDTH,POLY):
//   - ports i_clk, i_rst_n, i_clr, i_load, i_en, i_seed, i_data, o_sig
//   - generate one per channel
//  The top holds the FSM, counter, fold/compare registers and overrun flag.
// TESTING (NUM_CH=2, DATA_WIDTH=8, POLY=8'h1D unless noted)
//  1 Reset: hold i_rst_n=0 for 2 cycles -> all outputs 0, o_busy=0.
//  2 Unseeded: IDLE, vld=2'b11, data={8'h00,8'h05}, i_stop=1 on the next sample
//    {00,00} -> lane0: 05 then 0A; o_vld pulse, o_data=8'h0A, o_count=2.
//  3 Seeded: seed 8'h80 with vld=2'b11, data=0 in the same cycle; then i_stop=1
//    -> lanes 1D, then 3A each; fold 8'h00. With i_golden=0, o_pass=1.
//    With i_golden=8'h01, o_pass=0.
//  4 Length: i_len=3, three cycles vld=2'b01, data0=8'h01
//    -> lane0 01,03,07; lane1 00; o_data=8'h07, o_count=3.
//    o_vld is high the cycle after the third sample, with no i_stop.
//  5 Reset mid-RUN: i_rst_n=0 after 2 samples -> next cycle IDLE, o_ch_sig=0.
//    No o_vld pulse.
//  6 Overrun: vld=2'b10 during DONE -> o_overrun=1, the sample is absorbed nowhere.
//    The next run start clears o_overrun.

Source files
------------

// File: rtl/sig_analyzer_pkg.sv
// Shared types and the MISR step function for the multi-channel signature analyzer.
package sig_analyzer_pkg;

    typedef enum logic [1:0] {
        SA_IDLE = 2'd0,
        SA_RUN  = 2'd1,
        SA_DONE = 2'd2
    } st_sa_state;

    // Widest lane the shared step function supports; narrower lanes are zero-extended.
    localparam int unsigned MISR_MAX_W = 128;

    // One MISR shift: shift left, fold the dropped msb back through the tap mask, add data.
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] s,
        input logic [MISR_MAX_W-1:0] d,
        input logic [MISR_MAX_W-1:0] poly,
        input int unsigned           w
    );
        logic [MISR_MAX_W-1:0] mask;
        logic                  msb;
        mask = {MISR_MAX_W{1'b1}} >> (MISR_MAX_W - w);
        msb  = |(s & ({{(MISR_MAX_W-1){1'b0}}, 1'b1} << (w - 1)));
        return ((s << 1) ^ (msb ? poly : '0) ^ d) & mask;
    endfunction

endpackage

// File: rtl/misr_lane.sv
// Single MISR lane: clear, optional seed load, and data compaction on enable.
module misr_lane
    import sig_analyzer_pkg::*;
#(
    parameter int                    DATA_WIDTH = 54,
    parameter logic [DATA_WIDTH-1:0] POLY       = 'h63
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic                  i_load,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_seed,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_sig
);

    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] stepped;

    // A seed and a sample in the same cycle compact the sample onto the seed.
    assign base    = i_load ? i_seed : o_sig;
    assign stepped = DATA_WIDTH'(misr_step(MISR_MAX_W'(base), MISR_MAX_W'(i_data),
                                           MISR_MAX_W'(POLY), DATA_WIDTH));

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignment so every lane samples pre-edge values.
        if (!i_rst_n || i_clr) begin
            o_sig <= '0;
        end else if (i_en) begin
            o_sig <= stepped;
        end else if (i_load) begin
            o_sig <= i_seed;
        end
    end

endmodule

// File: rtl/multi_ch_signature_analyzer.sv
// Multi-lane MISR signature compactor with run control, XOR fold and golden compare.
module multi_ch_signature_analyzer
    import sig_analyzer_pkg::*;
#(
    parameter int                    NUM_CH     = 4,
    parameter int                    DATA_WIDTH = 54,
    parameter int                    CNT_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] POLY       = 'h63
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_stop,
    input  logic [CNT_WIDTH-1:0]         i_len,
    input  logic                         i_seed_vld,
    input  logic [DATA_WIDTH-1:0]        i_seed_data,
    input  logic [NUM_CH-1:0]            i_dut_vld,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_dut_data,
    input  logic [DATA_WIDTH-1:0]        i_golden,
    output logic                         o_busy,
    output logic                         o_vld,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_pass,
    output logic [CNT_WIDTH-1:0]         o_count,
    output logic                         o_overrun,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_ch_sig
);

    st_sa_state            state;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  count_inc;
    logic [CNT_WIDTH-1:0]  last_count;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] fold;
    logic                  pass_q;
    logic                  vld_q;
    logic                  overrun_q;
    logic                  sample;
    logic                  lane_load;
    logic                  lane_clr;
    logic [NUM_CH-1:0]     lane_en;

    assign sample    = |i_dut_vld;
    assign count_inc = (&count_q) ? count_q : count_q + 1'b1;
    assign lane_load = (state == SA_IDLE) && i_seed_vld;
    assign lane_clr  = (state == SA_DONE);
    assign lane_en   = (state == SA_DONE) ? '0 : i_dut_vld;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        misr_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .POLY       (POLY)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_clr   (lane_clr),
            .i_load  (lane_load),
            .i_en    (lane_en[k]),
            .i_seed  (i_seed_data),
            .i_data  (i_dut_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .o_sig   (o_ch_sig[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_comb begin
        // NOTE: default first so the loop accumulator can never infer a latch.
        fold = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            fold = fold ^ o_ch_sig[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= SA_IDLE;
            count_q    <= '0;
            last_count <= '0;
            len_q      <= '0;
            data_q     <= '0;
            pass_q     <= 1'b0;
            vld_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            case (state)
                SA_IDLE: begin
                    if (i_seed_vld || sample) begin
                        state     <= SA_RUN;
                        count_q   <= sample ? CNT_WIDTH'(1) : '0;
                        len_q     <= i_len;
                        overrun_q <= 1'b0;
                    end
                end
                SA_RUN: begin
                    if (sample) begin
                        count_q <= count_inc;
                    end
                    if (i_stop || (len_q != '0 && sample && count_inc == len_q)) begin
                        state <= SA_DONE;
                        vld_q <= 1'b1;
                    end
                end
                SA_DONE: begin
                    state      <= SA_IDLE;
                    count_q    <= '0;
                    last_count <= count_q;
                    data_q     <= fold;
                    pass_q     <= (fold == i_golden);
                    if (sample) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state <= SA_IDLE;
            endcase
        end
    end

    // During DONE the lanes already hold the final values, so the result is presented live.
    assign o_busy    = (state != SA_IDLE);
    assign o_vld     = vld_q;
    assign o_data    = vld_q ? fold : data_q;
    assign o_pass    = vld_q ? (fold == i_golden) : pass_q;
    assign o_count   = (state == SA_IDLE) ? last_count : count_q;
    assign o_overrun = overrun_q;

endmodule
